// File: rtl/adder_scheduler.sv
// adder_scheduler: round-robin front end for one shared pipelined 8-input adder.
// Tracks the owner id of each issued operation through a tag pipeline of depth
// ADDER_LAT and returns the registered result to that owner ADDER_LAT+2 cycles
// after acceptance. A flush_req level drains the pipeline (RUN/DRAIN/DRAINED).
// Optional build macro: ADDER_SCHED_STATS_EN adds issue_count / stall_count.
module adder_scheduler #(
   parameter int unsigned NUM_REQ   = 4,
   parameter int unsigned ADDER_LAT = 2
) (
   input  logic                   sysclk,
   input  logic                   reset_n,
   input  logic [NUM_REQ-1:0]     req_valid,
   output logic [NUM_REQ-1:0]     req_ready,
   input  logic [NUM_REQ*32-1:0]  req_data,
   input  logic [NUM_REQ*6-1:0]   req_mode,
   output logic                   adder_issue,
   output logic [63:0]            adder_data,
   output logic [5:0]             adder_mm,
   input  logic [7:0]             adder_result,
   output logic [NUM_REQ-1:0]     rsp_valid,
   output logic [7:0]             rsp_result,
   input  logic                   flush_req,
   output logic                   flush_done,
   output logic                   busy
`ifdef ADDER_SCHED_STATS_EN
   ,
   output logic [15:0]            issue_count,
   output logic [15:0]            stall_count
`endif
);

   localparam int unsigned ID_W    = 3;
   localparam int unsigned NIB_N   = 8;
   localparam int unsigned NIB_W   = 4;
   localparam int unsigned REQ_W   = NIB_N * NIB_W;
   localparam int unsigned MM_W    = 6;
   localparam int unsigned LANE_W  = 8;
   localparam int unsigned TAG_TOP = ADDER_LAT - 1;

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_DRAIN   = 2'd1,
      ST_DRAINED = 2'd2
   } state_t;

   state_t                          state_q, state_d;
   logic [ID_W-1:0]                 ptr_q, ptr_d;
   logic                            adder_issue_q, adder_issue_d;
   logic [63:0]                     adder_data_q, adder_data_d;
   logic [MM_W-1:0]                 adder_mm_q, adder_mm_d;
   logic [ID_W-1:0]                 issue_id_q, issue_id_d;
   logic [ADDER_LAT-1:0]            tag_v_q, tag_v_d;
   logic [ADDER_LAT-1:0][ID_W-1:0]  tag_id_q, tag_id_d;
   logic [NUM_REQ-1:0]              rsp_valid_q, rsp_valid_d;
   logic [7:0]                      rsp_result_q, rsp_result_d;
   logic                            flush_done_q, flush_done_d;
   logic                            busy_q, busy_d;

   logic [NUM_REQ-1:0]              grant_c;
   logic                            grant_hit;
   logic [ID_W-1:0]                 grant_idx;
   logic [REQ_W-1:0]                sel_data;
   logic [MM_W-1:0]                 sel_mode;

   // Round-robin pick: first valid at or above the pointer, else first below it.
   always_comb begin
      grant_hit = 1'b0;
      grant_idx = '0;
      grant_c   = '0;
      if (state_q == ST_RUN && !flush_req) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!grant_hit && req_valid[i] && (ID_W'(i) >= ptr_q)) begin
               grant_hit = 1'b1;
               grant_idx = ID_W'(i);
            end
         end
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!grant_hit && req_valid[i] && (ID_W'(i) < ptr_q)) begin
               grant_hit = 1'b1;
               grant_idx = ID_W'(i);
            end
         end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         grant_c[i] = grant_hit && (grant_idx == ID_W'(i));
      end
   end

   // Operand mux for the granted requester.
   always_comb begin
      sel_data = '0;
      sel_mode = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_c[i]) begin
            sel_data = req_data[i*REQ_W +: REQ_W];
            sel_mode = req_mode[i*MM_W +: MM_W];
         end
      end
   end

   // FSM next state: RUN -> DRAIN on flush, DRAIN -> DRAINED once idle, back on release.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN:     if (flush_req) state_d = ST_DRAIN;
         ST_DRAIN:   if (!busy_q) state_d = ST_DRAINED;
         ST_DRAINED: if (!flush_req) state_d = ST_RUN;
         default:    state_d = ST_RUN;
      endcase
   end

   // Issue register, pointer update, tag pipeline and response capture.
   always_comb begin
      ptr_d         = ptr_q;
      adder_issue_d = grant_hit;
      adder_data_d  = adder_data_q;
      adder_mm_d    = adder_mm_q;
      issue_id_d    = issue_id_q;
      rsp_valid_d   = '0;
      rsp_result_d  = rsp_result_q;

      if (grant_hit) begin
         ptr_d      = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
         issue_id_d = grant_idx;
         adder_mm_d = sel_mode;
         for (int n = 0; n < NIB_N; n++) begin
            adder_data_d[n*LANE_W +: LANE_W] = {4'b0, sel_data[n*NIB_W +: NIB_W]};
         end
      end

      tag_v_d[0]  = adder_issue_q;
      tag_id_d[0] = issue_id_q;
      for (int k = 1; k < ADDER_LAT; k++) begin
         tag_v_d[k]  = tag_v_q[k-1];
         tag_id_d[k] = tag_id_q[k-1];
      end

      if (tag_v_q[TAG_TOP]) begin
         rsp_result_d = adder_result;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         rsp_valid_d[i] = tag_v_q[TAG_TOP] && (tag_id_q[TAG_TOP] == ID_W'(i));
      end

      busy_d       = adder_issue_d | (|tag_v_d);
      flush_done_d = (state_d == ST_DRAINED);
   end

   // State and datapath registers; reset drops everything in flight.
   always_ff @(posedge sysclk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= ST_RUN;
         ptr_q         <= '0;
         adder_issue_q <= 1'b0;
         adder_data_q  <= '0;
         adder_mm_q    <= '0;
         issue_id_q    <= '0;
         tag_v_q       <= '0;
         tag_id_q      <= '0;
         rsp_valid_q   <= '0;
         rsp_result_q  <= '0;
         flush_done_q  <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         ptr_q         <= ptr_d;
         adder_issue_q <= adder_issue_d;
         adder_data_q  <= adder_data_d;
         adder_mm_q    <= adder_mm_d;
         issue_id_q    <= issue_id_d;
         tag_v_q       <= tag_v_d;
         tag_id_q      <= tag_id_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_result_q  <= rsp_result_d;
         flush_done_q  <= flush_done_d;
         busy_q        <= busy_d;
      end
   end

   assign req_ready   = grant_c;
   assign adder_issue = adder_issue_q;
   assign adder_data  = adder_data_q;
   assign adder_mm    = adder_mm_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_result  = rsp_result_q;
   assign flush_done  = flush_done_q;
   assign busy        = busy_q;

`ifdef ADDER_SCHED_STATS_EN
   logic [15:0] issue_count_q, issue_count_d;
   logic [15:0] stall_count_q, stall_count_d;

   // Saturating accept / starvation counters.
   always_comb begin
      issue_count_d = issue_count_q;
      stall_count_d = stall_count_q;
      if (grant_hit && issue_count_q != 16'hFFFF) begin
         issue_count_d = issue_count_q + 16'd1;
      end
      if ((|req_valid) && !grant_hit && stall_count_q != 16'hFFFF) begin
         stall_count_d = stall_count_q + 16'd1;
      end
   end

   // Counter registers.
   always_ff @(posedge sysclk or negedge reset_n) begin
      if (!reset_n) begin
         issue_count_q <= '0;
         stall_count_q <= '0;
      end else begin
         issue_count_q <= issue_count_d;
         stall_count_q <= stall_count_d;
      end
   end

   assign issue_count = issue_count_q;
   assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_adder_scheduler.sv
// Scoreboard bench for adder_scheduler: stimulus predicts grants with a modulo
// round-robin model and queues expected issues/responses; a negedge monitor
// compares adder_issue and rsp_valid/rsp_result against the queue heads.
module tb_adder_scheduler;

   localparam int NREQ = 4;
   localparam int LAT  = 2;

   logic                 sysclk;
   logic                 reset_n;
   logic [NREQ-1:0]      req_valid;
   logic [NREQ-1:0]      req_ready;
   logic [NREQ*32-1:0]   req_data;
   logic [NREQ*6-1:0]    req_mode;
   logic                 adder_issue;
   logic [63:0]          adder_data;
   logic [5:0]           adder_mm;
   logic [7:0]           adder_result;
   logic [NREQ-1:0]      rsp_valid;
   logic [7:0]           rsp_result;
   logic                 flush_req;
   logic                 flush_done;
   logic                 busy;
`ifdef ADDER_SCHED_STATS_EN
   logic [15:0]          issue_count;
   logic [15:0]          stall_count;
`endif

   adder_scheduler #(.NUM_REQ(NREQ), .ADDER_LAT(LAT)) dut (
      .sysclk       (sysclk),
      .reset_n      (reset_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_data     (req_data),
      .req_mode     (req_mode),
      .adder_issue  (adder_issue),
      .adder_data   (adder_data),
      .adder_mm     (adder_mm),
      .adder_result (adder_result),
      .rsp_valid    (rsp_valid),
      .rsp_result   (rsp_result),
      .flush_req    (flush_req),
      .flush_done   (flush_done),
      .busy         (busy)
`ifdef ADDER_SCHED_STATS_EN
      ,
      .issue_count  (issue_count),
      .stall_count  (stall_count)
`endif
   );

   typedef struct {
      int          id;
      logic [63:0] data;
      logic [5:0]  mm;
      logic [7:0]  sum;
      int          cyc;
   } exp_t;

   exp_t        iss_q[$];
   exp_t        rsp_q[$];
   int          n_pass = 0;
   int          n_fail = 0;
   int          cyc = 0;
   int          mptr = 0;
   int          exp_issue = 0;
   int          exp_stall = 0;
   int          last_acc = 0;
   logic [31:0] dw [NREQ];
   logic [5:0]  mw [NREQ];
   bit          fix_en = 0;
   logic [31:0] fix_data = '0;
   logic [5:0]  fix_mode = '0;
   logic [7:0]  pipe [LAT];

   initial begin
      sysclk = 1'b0;
      forever #5 sysclk = ~sysclk;
   end

   always @(posedge sysclk) cyc <= cyc + 1;

   // Behavioural adder: byte-lane sum of adder_data, ADDER_LAT cycles later.
   initial for (int k = 0; k < LAT; k++) pipe[k] = '0;
   always @(posedge sysclk) begin
      int s;
      s = 0;
      for (int n = 0; n < 8; n++) s += int'(adder_data[n*8 +: 8]);
      pipe[0] <= 8'(s);
      for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
   end
   assign adder_result = pipe[LAT-1];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      if (act === exp) n_pass++;
      else begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [63:0] pack(input logic [31:0] w);
      logic [63:0] d;
      for (int n = 0; n < 8; n++) d[n*8 +: 8] = {4'h0, w[n*4 +: 4]};
      return d;
   endfunction

   function automatic logic [7:0] nsum(input logic [31:0] w);
      int s;
      s = 0;
      for (int n = 0; n < 8; n++) s += int'(w[n*4 +: 4]);
      return 8'(s);
   endfunction

   // One stimulus cycle: drive at negedge, predict and check the grant.
   task automatic cycle(input logic [NREQ-1:0] mask, input logic flush, input bit allow);
      int              g;
      logic [NREQ-1:0] exp_rdy;
      exp_t            e;
      @(negedge sysclk);
      req_valid = mask;
      flush_req = flush;
      for (int i = 0; i < NREQ; i++) begin
         dw[i] = $urandom;
         mw[i] = 6'($urandom);
      end
      if (fix_en) begin
         dw[0] = fix_data;
         mw[0] = fix_mode;
      end
      for (int i = 0; i < NREQ; i++) begin
         req_data[i*32 +: 32] = dw[i];
         req_mode[i*6 +: 6]   = mw[i];
      end
      #1;
      g = -1;
      if (allow) begin
         for (int k = 0; k < NREQ; k++) begin
            if (g < 0 && mask[(mptr + k) % NREQ]) g = (mptr + k) % NREQ;
         end
      end
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      chk("req_ready", 64'(req_ready), 64'(exp_rdy));
      if (g >= 0) begin
         e.id   = g;
         e.data = pack(dw[g]);
         e.mm   = mw[g];
         e.sum  = nsum(dw[g]);
         e.cyc  = cyc;
         iss_q.push_back(e);
         rsp_q.push_back(e);
         mptr      = (g + 1) % NREQ;
         last_acc  = cyc;
         exp_issue++;
      end else if (mask != '0) begin
         exp_stall++;
      end
   endtask

   // Monitor: every output cycle must match whatever is due at the queue heads.
   always @(negedge sysclk) begin
      if (reset_n) begin
         bit              due_i, due_r;
         logic [NREQ-1:0] oh;
         exp_t            e;
         due_i = (iss_q.size() > 0) && (iss_q[0].cyc + 1 == cyc);
         chk("adder_issue", 64'(adder_issue), 64'(due_i));
         if (due_i) begin
            e = iss_q.pop_front();
            chk("adder_data", adder_data, e.data);
            chk("adder_mm", 64'(adder_mm), 64'(e.mm));
         end
         due_r = (rsp_q.size() > 0) && (rsp_q[0].cyc + LAT + 2 == cyc);
         oh = '0;
         if (due_r) oh[rsp_q[0].id] = 1'b1;
         chk("rsp_valid", 64'(rsp_valid), 64'(oh));
         if (due_r) begin
            e = rsp_q.pop_front();
            chk("rsp_result", 64'(rsp_result), 64'(e.sum));
         end
      end
   end

   task automatic chk_all_zero(input string tag);
      chk({tag, "_req_ready"}, 64'(req_ready), 64'(0));
      chk({tag, "_adder_issue"}, 64'(adder_issue), 64'(0));
      chk({tag, "_adder_data"}, adder_data, 64'(0));
      chk({tag, "_adder_mm"}, 64'(adder_mm), 64'(0));
      chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(0));
      chk({tag, "_rsp_result"}, 64'(rsp_result), 64'(0));
      chk({tag, "_flush_done"}, 64'(flush_done), 64'(0));
      chk({tag, "_busy"}, 64'(busy), 64'(0));
   endtask

   initial begin
      int done_cyc;
      reset_n   = 1'b0;
      req_valid = '0;
      req_data  = '0;
      req_mode  = '0;
      flush_req = 1'b0;
      repeat (2) @(posedge sysclk);
      #1;
      chk_all_zero("reset");
      @(negedge sysclk);
      reset_n = 1'b1;

      // Single request: latency and packing with known operands.
      fix_en   = 1;
      fix_data = 32'h87654321;
      fix_mode = 6'b000111;
      cycle(4'b0001, 1'b0, 1'b1);
      fix_en = 0;
      cycle('0, 1'b0, 1'b1);
      chk("single_issue", 64'(adder_issue), 64'(1));
      chk("single_data", adder_data, 64'h0807060504030201);
      chk("single_mm", 64'(adder_mm), 64'(6'b000111));
      chk("single_busy", 64'(busy), 64'(1));
      repeat (3) cycle('0, 1'b0, 1'b1);
      chk("single_rsp_valid", 64'(rsp_valid), 64'(4'b0001));
      chk("single_rsp_result", 64'(rsp_result), 64'(8'h24));

      // Full contention: strict rotation.
      repeat (8) cycle(4'b1111, 1'b0, 1'b1);
      repeat (6) cycle('0, 1'b0, 1'b1);

      // Wrap and skip.
      cycle(4'b0100, 1'b0, 1'b1);
      cycle(4'b0010, 1'b0, 1'b1);
      cycle(4'b1001, 1'b0, 1'b1);
      repeat (6) cycle('0, 1'b0, 1'b1);

      // Flush with three ops in flight.
      repeat (3) cycle(4'b1111, 1'b0, 1'b1);
      done_cyc = -1;
      for (int k = 0; k < 20 && done_cyc < 0; k++) begin
         cycle(4'b1111, 1'b1, 1'b0);
         if (flush_done) done_cyc = cyc;
      end
      if (done_cyc < 0) chk("flush_done_timeout", 64'(flush_done), 64'(1));
      else begin
         chk("flush_done_cycle", 64'(done_cyc), 64'(last_acc + 5));
         chk("flush_busy", 64'(busy), 64'(0));
      end
      cycle(4'b1111, 1'b0, 1'b0);
      chk("drained_hold", 64'(flush_done), 64'(1));
      cycle(4'b1111, 1'b0, 1'b1);
      chk("flush_done_clear", 64'(flush_done), 64'(0));
      repeat (6) cycle('0, 1'b0, 1'b1);

      // Async reset during DRAIN with two ops pending.
      cycle(4'b1111, 1'b0, 1'b1);
      cycle(4'b1111, 1'b0, 1'b1);
      cycle('0, 1'b1, 1'b0);
      @(negedge sysclk);
      reset_n   = 1'b0;
      flush_req = 1'b0;
      #1;
      chk_all_zero("midreset");
      #3;
      reset_n = 1'b1;
      iss_q.delete();
      rsp_q.delete();
      mptr      = 0;
      exp_issue = 0;
      exp_stall = 0;
      cycle(4'b1111, 1'b0, 1'b1);
      chk("post_reset_flush_done", 64'(flush_done), 64'(0));
      repeat (8) cycle('0, 1'b0, 1'b1);

      // Randomised traffic.
      for (int k = 0; k < 300; k++) begin
         cycle(($urandom_range(0, 3) == 0) ? '0 : 4'($urandom), 1'b0, 1'b1);
      end
      repeat (8) cycle('0, 1'b0, 1'b1);

`ifdef ADDER_SCHED_STATS_EN
      chk("issue_count", 64'(issue_count), 64'(exp_issue));
      chk("stall_count", 64'(stall_count), 64'(exp_stall));
`endif

      $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
      $finish;
   end

endmodule
